shift_reg_univ: RTL and testbench
=================================

// Module: shift_reg_univ
// PURPOSE
//  Parametrised universal shift register: N stages of W-bit lanes with shift, rotate,
//  parallel load and clear, serial I/O at both ends and full parallel readout.
//  Adds a burst engine that runs one op for a programmed count with busy/done status.
//  Serves as the serialiser/deserialiser and data-alignment element in datapaths.
// PARAMETERS
//  W      1  lane width in bits (W >= 1)
//  N      4  number of stages (N >= 2)
//  CNT_W  3  burst count width; burst length 0..2**CNT_W-1
// PORTS
//  clk     in   1      clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  en      in   1      single-step enable (IDLE only)
//  op      in   3      operation code, see BEHAVIOUR
//  start   in   1      launch burst of op for cnt steps (IDLE only)
//  cnt     in   CNT_W  burst length
//  abort   in   1      stop a running burst
//  sin_lo  in   W      serial in at stage 0 (SHL)
//  sin_hi  in   W      serial in at stage N-1 (SHR)
//  pin     in   N*W    parallel load data; stage i = pin[i*W +: W]
//  pout    out  N*W    parallel contents; stage i = pout[i*W +: W]
//  sout_lo out  W      stage 0 contents
//  sout_hi out  W      stage N-1 contents
//  busy    out  1      burst in progress
//  done    out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset (async): all stages 0, busy=0, done=0, FSM=IDLE, count=0. Reset mid-burst aborts it.
//  - pout, sout_lo and sout_hi are wired directly from stage flops; no extra output register.
//  - Ops, one step per edge: 000 HOLD; 001 SHR s[i]<=s[i+1], s[N-1]<=sin_hi;
//    010 SHL s[i]<=s[i-1], s[0]<=sin_lo; 011 ROR s[i]<=s[i+1], s[N-1]<=s[0];
//    100 ROL s[i]<=s[i-1], s[0]<=s[N-1]; 101 LOAD s<=pin; 110 CLEAR s<=0; 111 reserved = HOLD.
//  - Serial inputs are sampled on each step edge, so a burst SHR/SHL takes a new sin each step.
//  - FSM IDLE/RUN.
//  - IDLE, start=0, en=1: execute op once at the edge.
//  - IDLE, start=1: start takes priority over en. Latch op into op_q and cnt into rem; no step at this edge.
//    - cnt=0: stay IDLE, done=1 for the next cycle, data unchanged.
//    - cnt>0: go to RUN, busy=1.
//  - RUN: each edge executes op_q and decrements rem. The edge that takes rem 1->0 performs
//    the last step, goes to IDLE, clears busy and sets done for one cycle.
//    Result: busy is high for exactly cnt cycles.
//  - RUN: en, start, op and cnt are ignored. abort=1 -> IDLE at that edge, no step, no done.
//    Data reflects only the steps already completed.
//  - Burst LOAD/CLEAR/HOLD is legal and repeats the op. Shift counts > N are legal:
//    SHR/SHL just keep filling from sin, and rotates wrap modulo N.
//  - done and busy are never high in the same cycle.
// STRUCTURE
//  - shift_reg_pkg: OP_* localparams (3-bit op codes) and ST_IDLE/ST_RUN state encodings.
//  - Sub-module shift_burst_ctl: FSM, rem counter, op_q latch, busy/done.
//    It drives a step strobe and the effective op.
//  - Top level holds the stage array and the next-state mux, using generate over N.
// TESTING (W=4, N=4, pout shown stage3..stage0)
//  1. en, op=LOAD, pin=0x4321 -> pout=0x4321, sout_lo=1, sout_hi=4;
//     then SHR with sin_hi=A -> pout=0xA432, sout_lo=2.
//  2. From 0x4321: start, op=ROL, cnt=3 -> busy high 3 cycles, steps 0x3214, 0x2143, 0x1432;
//     done pulses 1 cycle after busy drops.
//  3. start, cnt=0 -> busy never high, done=1 next cycle only, pout unchanged.
//  4. Burst SHL cnt=5 from 0x4321 with sin_lo=5,6,7,8,9; abort asserted after 2 steps
//     -> pout=0x2156, busy=0, no done; op/en toggling during RUN has no effect.
//  5. Assert rst mid-burst (async, between edges) -> pout=0, busy=0, done=0 immediately;
//     next start works normally.
//  6. op=111 with en -> pout unchanged; op=CLEAR -> pout=0;
//     start+en together in IDLE -> only the burst launches.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared op codes and burst-FSM state encoding for the universal shift register.
package shift_reg_pkg;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_ROR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } burst_state_t;

endpackage

// File: rtl/shift_burst_ctl.sv
// Burst controller: single steps in IDLE, counted repeats of a latched op in RUN,
// producing a step strobe, the op to apply, and busy/done status.
module shift_burst_ctl
    import shift_reg_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [2:0]       op_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             abort_i,
    output logic             step_o,
    output logic [2:0]       eff_op_o,
    output logic             busy_o,
    output logic             done_o
);

    burst_state_t     state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            op_q    <= OP_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        op_d     = op_q;
        done_d   = 1'b0;
        step_o   = 1'b0;
        eff_op_o = op_i;
        case (state_q)
            ST_IDLE: begin
                // A launch edge never steps; a zero-length burst completes immediately.
                if (start_i) begin
                    op_d = op_i;
                    rem_d = cnt_i;
                    if (cnt_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (en_i) begin
                    step_o = 1'b1;
                end
            end
            ST_RUN: begin
                eff_op_o = op_q;
                if (abort_i) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else begin
                    step_o = 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal N-stage, W-bit-lane shift register with shift/rotate/load/clear
// and a counted burst engine.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int W     = 1,
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    input  logic             abort,
    input  logic [W-1:0]     sin_lo,
    input  logic [W-1:0]     sin_hi,
    input  logic [N*W-1:0]   pin,
    output logic [N*W-1:0]   pout,
    output logic [W-1:0]     sout_lo,
    output logic [W-1:0]     sout_hi,
    output logic             busy,
    output logic             done
);

    logic       step;
    logic [2:0] eff_op;
    logic [W-1:0] stage [N];

    shift_burst_ctl #(.CNT_W(CNT_W)) u_ctl (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en),
        .op_i     (op),
        .start_i  (start),
        .cnt_i    (cnt),
        .abort_i  (abort),
        .step_o   (step),
        .eff_op_o (eff_op),
        .busy_o   (busy),
        .done_o   (done)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            logic [W-1:0] stage_q, stage_d;
            logic [W-1:0] shr_src, ror_src, shl_src, rol_src;

            // End stages take the serial input on shifts and the opposite end on rotates.
            if (gi == N-1) begin : g_top
                assign shr_src = sin_hi;
                assign ror_src = stage[0];
            end else begin : g_mid_hi
                assign shr_src = stage[gi+1];
                assign ror_src = stage[gi+1];
            end
            if (gi == 0) begin : g_bot
                assign shl_src = sin_lo;
                assign rol_src = stage[N-1];
            end else begin : g_mid_lo
                assign shl_src = stage[gi-1];
                assign rol_src = stage[gi-1];
            end

            always_comb begin
                stage_d = stage_q;
                case (eff_op)
                    OP_SHR:   stage_d = shr_src;
                    OP_SHL:   stage_d = shl_src;
                    OP_ROR:   stage_d = ror_src;
                    OP_ROL:   stage_d = rol_src;
                    OP_LOAD:  stage_d = pin[gi*W +: W];
                    OP_CLEAR: stage_d = '0;
                    default:  stage_d = stage_q;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_q <= '0;
                end else if (step) begin
                    stage_q <= stage_d;
                end
            end

            assign stage[gi]       = stage_q;
            assign pout[gi*W +: W] = stage_q;
        end
    endgenerate

    assign sout_lo = stage[0];
    assign sout_hi = stage[N-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ at W=4, N=4, CNT_W=3; pout is shown stage3..stage0.
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic        start;
    logic [2:0]  cnt;
    logic        abort;
    logic [3:0]  sin_lo;
    logic [3:0]  sin_hi;
    logic [15:0] pin;
    logic [15:0] pout;
    logic [3:0]  sout_lo;
    logic [3:0]  sout_hi;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    shift_reg_univ #(.W(4), .N(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .op      (op),
        .start   (start),
        .cnt     (cnt),
        .abort   (abort),
        .sin_lo  (sin_lo),
        .sin_hi  (sin_hi),
        .pin     (pin),
        .pout    (pout),
        .sout_lo (sout_lo),
        .sout_hi (sout_hi),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-18s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic status(input string tag, input logic [15:0] p, input logic b, input logic d);
        check({tag, ".pout"}, pout, p);
        check({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
        check({tag, ".done"}, {15'd0, done}, {15'd0, d});
    endtask

    task automatic load(input logic [15:0] val);
        en = 1'b1; op = OP_LOAD; pin = val;
        tick();
        en = 1'b0; op = OP_HOLD;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = OP_HOLD; start = 1'b0; cnt = 3'd0;
        abort = 1'b0; sin_lo = 4'h0; sin_hi = 4'h0; pin = 16'h0;
        #1;
        status("reset", 16'h0000, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        status("post_reset", 16'h0000, 1'b0, 1'b0);

        // 1. single-step LOAD then SHR
        load(16'h4321);
        check("load.pout", pout, 16'h4321);
        check("load.sout_lo", {12'd0, sout_lo}, 16'h0001);
        check("load.sout_hi", {12'd0, sout_hi}, 16'h0004);
        en = 1'b1; op = OP_SHR; sin_hi = 4'hA;
        tick();
        en = 1'b0; op = OP_HOLD;
        check("shr.pout", pout, 16'hA432);
        check("shr.sout_lo", {12'd0, sout_lo}, 16'h0002);

        // 2. ROL burst of 3
        load(16'h4321);
        start = 1'b1; op = OP_ROL; cnt = 3'd3;
        tick();
        start = 1'b0; op = OP_HOLD; cnt = 3'd0;
        status("rol.launch", 16'h4321, 1'b1, 1'b0);
        tick();
        status("rol.step1", 16'h3214, 1'b1, 1'b0);
        tick();
        status("rol.step2", 16'h2143, 1'b1, 1'b0);
        tick();
        status("rol.step3", 16'h1432, 1'b0, 1'b1);
        tick();
        status("rol.after", 16'h1432, 1'b0, 1'b0);

        // 3. zero-length burst
        start = 1'b1; op = OP_SHR; cnt = 3'd0;
        tick();
        start = 1'b0; op = OP_HOLD;
        status("cnt0.launch", 16'h1432, 1'b0, 1'b1);
        tick();
        status("cnt0.after", 16'h1432, 1'b0, 1'b0);

        // 4. SHL burst of 5 aborted after two steps; en/op noise during RUN
        load(16'h4321);
        start = 1'b1; op = OP_SHL; cnt = 3'd5; sin_lo = 4'h5;
        tick();
        start = 1'b0; en = 1'b1; op = OP_CLEAR; cnt = 3'd7;
        status("shl.launch", 16'h4321, 1'b1, 1'b0);
        tick();
        sin_lo = 4'h6; op = OP_LOAD; pin = 16'hFFFF;
        status("shl.step1", 16'h3215, 1'b1, 1'b0);
        tick();
        sin_lo = 4'h7;
        status("shl.step2", 16'h2156, 1'b1, 1'b0);
        abort = 1'b1; en = 1'b0; op = OP_HOLD;
        tick();
        abort = 1'b0;
        status("shl.abort", 16'h2156, 1'b0, 1'b0);
        tick();
        status("shl.after", 16'h2156, 1'b0, 1'b0);

        // 5. async reset mid-burst, then a fresh burst
        load(16'h4321);
        start = 1'b1; op = OP_ROL; cnt = 3'd5;
        tick();
        start = 1'b0; op = OP_HOLD;
        tick();
        status("rst.pre", 16'h3214, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        status("rst.async", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        start = 1'b1; op = OP_LOAD; cnt = 3'd1; pin = 16'h4321;
        tick();
        start = 1'b0; op = OP_HOLD;
        status("rst.relaunch", 16'h0000, 1'b1, 1'b0);
        tick();
        status("rst.burst", 16'h4321, 1'b0, 1'b1);

        // 6. reserved op, CLEAR, start+en priority
        en = 1'b1; op = OP_RSVD;
        tick();
        en = 1'b0;
        check("rsvd.pout", pout, 16'h4321);
        en = 1'b1; op = OP_CLEAR;
        tick();
        en = 1'b0;
        check("clear.pout", pout, 16'h0000);
        load(16'h4321);
        start = 1'b1; en = 1'b1; op = OP_SHR; cnt = 3'd2; sin_hi = 4'hB;
        tick();
        start = 1'b0; en = 1'b0; op = OP_HOLD;
        status("prio.launch", 16'h4321, 1'b1, 1'b0);
        tick();
        status("prio.step1", 16'hB432, 1'b1, 1'b0);
        tick();
        status("prio.step2", 16'hBB43, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
